// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
// Optional exception redirect on misaligned jr targets: define PC_EXC_EN.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    HALTED
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC
  } sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  function automatic logic [31:0] br_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: jr > jump > branch > sequential.
// With PC_EXC_EN a misaligned jr target selects the exception vector.
module next_pc_calc
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output sel_e        sel
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + br_disp(branch_offset);
  assign j_tgt    = {pc_plus4[31:28], jump_target, 2'b00};
  assign jr_tgt   = jr_target & 32'hFFFF_FFFC;

  always_comb begin
    sel = SEL_SEQ;
    if (jr) begin
`ifdef PC_EXC_EN
      sel = (|jr_target[1:0]) ? SEL_EXC : SEL_JR;
`else
      sel = SEL_JR;
`endif
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      SEL_SEQ: next_pc = pc_plus4;
      SEL_BR:  next_pc = br_tgt;
      SEL_J:   next_pc = j_tgt;
      SEL_JR:  next_pc = jr_tgt;
      SEL_EXC: next_pc = EXC_VECTOR;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch handshake, execute window, next-PC load, halt.
// Define PC_EXC_EN to add epc/exc_pulse and misaligned-jr redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        halted
`ifdef PC_EXC_EN
  ,
  output logic [31:0] epc,
  output logic        exc_pulse
`endif
);

  state_e      state;
  sel_e        sel;
  logic [31:0] next_pc;
  logic        exc_hit;

  next_pc_calc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_calc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .sel          (sel)
  );

  assign exc_hit   = (sel == SEL_EXC);
  assign imem_addr = pc;

`ifdef PC_EXC_EN
  assign exc_pulse = instr_valid && exc_hit;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef PC_EXC_EN
      epc         <= 32'h0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH, WAIT: begin
          if (imem_ready) begin
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        EXEC: begin
          // A faulting jr outranks halt and stall.
          if (exc_hit || (!halt && !stall)) begin
            pc          <= next_pc;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
`ifdef PC_EXC_EN
            if (exc_hit) epc <= jr_target;
`endif
          end else if (halt) begin
            state       <= HALTED;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the program counter of the MIPS core.
- Issues instruction fetches to instruction memory over a req/ready handshake.
- Presents each fetched instruction's PC to the datapath for one execute cycle.
- Selects the next PC from the datapath control outputs (sequential, branch, jump, jr) and handles stall and halt. Sits between the instruction memory and the decode/execute datapath.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, exception handler address (used only with PC_EXC_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, equal to pc
- imem_ready  in  1  fetch done; instruction valid at the memory this cycle
- instr_valid  out  1  execute cycle for the instruction at pc
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, combinational
- stall  in  1  datapath hold request; sampled only when instr_valid=1
- halt  in  1  stop fetching; sampled only when instr_valid=1
- branch_taken  in  1  conditional branch resolved taken
- branch_offset  in  16  raw immediate field
- jump  in  1  J/JAL
- jump_target  in  26  instr_index field
- jr  in  1  JR/JALR
- jr_target  in  32  register value
- halted  out  1  sequencer is in HALTED

Behaviour:
- Reset (asynchronous, active-low): pc=RESET_VECTOR, state=IDLE, imem_req=0, instr_valid=0, halted=0.
- States:
  - IDLE: move to FETCH on the next edge after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc. If imem_ready=1 in the same cycle, go to EXEC. Otherwise go to WAIT.
  - WAIT: imem_req stays 1 and imem_addr stays stable. Go to EXEC on imem_ready=1.
  - EXEC: instr_valid=1 and imem_req=0; the next PC is resolved in this cycle:
    - halt=1 → HALTED; pc holds.
    - else stall=1 → stay in EXEC; pc holds; instr_valid stays 1.
    - else → pc is loaded with the next PC, then FETCH.
  - HALTED: halted=1, no requests; exit only by reset.
- Fetch latency: minimum two cycles per instruction (FETCH+EXEC) when imem_ready is combinational. Each WAIT cycle adds one.
- Next-PC priority, highest first: jr > jump > branch_taken > pc_plus4. Simultaneous asserts resolve by priority with no error.
- Arithmetic, all modulo 2^32 with silent wrap:
  - branch target = pc_plus4 + {{14{off[15]}}, off, 2'b00}
  - jump target = {pc_plus4[31:28], jump_target, 2'b00}
  - jr target = jr_target with bits [1:0] forced to 0 (without PC_EXC_EN)
- imem_ready outside FETCH/WAIT is ignored.
- Reset mid-WAIT: imem_req drops asynchronously; any later imem_ready is ignored until FETCH.

Optional Feature:
- PC_EXC_EN defined:
  - A jr target with nonzero [1:0] redirects pc to EXC_VECTOR instead of the target.
  - The faulting target is latched into an extra output epc[31:0] (reset 0).
  - A one-cycle exc_pulse output is asserted in that EXEC cycle.
  - The misalignment check has priority above halt/stall.
- Undefined: no epc/exc_pulse ports; misaligned jr targets are truncated as above.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {IDLE, FETCH, WAIT, EXEC, HALTED}
  - next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC}
  - default vector constants
- Sub-module next_pc_calc: purely combinational; computes pc_plus4, the three targets and the selected next PC with its select code. The FSM and the pc register live in pc_sequencer.

Test Plan:
- Reset, release, imem_ready tied 1 → imem_addr 0 at cycle 1, instr_valid cycle 2, pc 4 at cycle 3 FETCH; 0,4,8,C sequence.
- imem_ready delayed 3 cycles → imem_addr held at 0x8 for 4 cycles; instr_valid once.
- Branch at pc 0x10, offset 16'hFFFF → next pc 0x10 (self-loop). Offset 0x0003 → 0x20.
- jr=1, jump=1, branch_taken=1 together, jr_target 0x100 → pc 0x100. Jump alone, pc 0x4000_0000, index 0x3 → 0x4000_000C.
- pc 0xFFFF_FFFC sequential → 0x0000_0000. Stall held 3 EXEC cycles → pc constant, instr_valid high 4 cycles.
- Halt in EXEC → halted=1, no imem_req for 10 cycles. Reset asserted mid-WAIT → pc=RESET_VECTOR, imem_req=0 immediately.
